bshift_ctrl: RTL and testbench

- Sequencing stage placed directly upstream of the 4-bit rotate-right barrel shifter (4:1 mux per bit, 2-bit select). It also consumes the shifter's output.
- Accepts rotate commands over a valid/ready handshake and drives the shifter's data and select lines.
- Waits a programmable settle time for the shifter's gate delay before it registers the shifter output. It can feed the result back for repeated passes.
- Returns the final word over a valid/ready output handshake.

---
 rtl/bshift_ctrl.sv | 142 ++++++++++++++
 tb/tb_bshift_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bshift_ctrl.sv
// bshift_ctrl: sequencing stage wrapped around a 4-bit rotate-right barrel
// shifter. It accepts a rotate command, drives the shifter for one or more
// passes, waits a settle window per pass, and returns the final word.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high. A producer holds valid and its payload
// stable until that edge. in_ready and out_valid are decoded from registered
// state only, so neither depends combinationally on the other side's signal.
module bshift_ctrl #(
    parameter int SETTLE_CYCLES = 5,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    input  logic [1:0]       in_amt,
    input  logic [CNT_W-1:0] in_cnt,
    output logic [3:0]       sh_a,
    output logic             sh_s1,
    output logic             sh_s0,
    input  logic [3:0]       sh_o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    // Settle counter is one bit wider than strictly needed so that the
    // terminal value SETTLE_CYCLES-1 always fits and the count never wraps.
    localparam int            CW   = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       work;
    logic [1:0]       amt;
    logic [CNT_W-1:0] passes;
    logic [CW-1:0]    cnt;
    logic             settled;

    // A pass ends on the edge where the shifter inputs have been stable
    // for SETTLE_CYCLES cycles.
    assign settled = (state == WAIT) && (cnt == LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = (in_cnt == '0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (settled && (passes == CNT_W'(1))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: command latch, settle counter, per-pass feedback, result.
    always_ff @(posedge clk) begin
        if (rst) begin
            work     <= '0;
            amt      <= '0;
            passes   <= '0;
            cnt      <= '0;
            out_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        work   <= in_data;
                        amt    <= in_amt;
                        passes <= in_cnt;
                        cnt    <= '0;
                        // Zero passes bypasses the shifter entirely.
                        if (in_cnt == '0) begin
                            out_data <= in_data;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == LAST) begin
                        work   <= sh_o;
                        passes <= passes - CNT_W'(1);
                        cnt    <= '0;
                        if (passes == CNT_W'(1)) begin
                            out_data <= sh_o;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    // Result held until the consumer takes it.
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // Outputs are pure decodes of registered state, so the shifter inputs
    // cannot move inside a settle window.
    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == DONE);
        sh_a      = work;
        sh_s1     = (state == WAIT) ? amt[1] : 1'b0;
        sh_s0     = (state == WAIT) ? amt[0] : 1'b0;
        state_dbg = state;
    end

endmodule

// File: tb/tb_bshift_ctrl.sv
// Testbench for bshift_ctrl: slow-shifter model, directed scenarios and a
// randomized command stream scored against an arithmetic rotate model.
module tb_bshift_ctrl;

    localparam int S     = 5;
    localparam int CNT_W = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_data;
    logic [1:0]       in_amt;
    logic [CNT_W-1:0] in_cnt;
    logic [3:0]       sh_a;
    logic             sh_s1;
    logic             sh_s0;
    logic [3:0]       sh_o = 4'd0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [3:0]       out_data;
    logic             busy;
    logic [1:0]       state_dbg;

    bshift_ctrl #(.SETTLE_CYCLES(S), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amt(in_amt), .in_cnt(in_cnt),
        .sh_a(sh_a), .sh_s1(sh_s1), .sh_s0(sh_s0), .sh_o(sh_o),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int         total = 0;
    int         bad   = 0;
    logic [3:0] exp_q[$];
    logic [3:0] sh_q[$];
    logic [3:0] pend_d;
    logic [1:0] pend_a;
    int         pend_c;
    int         rdy_mode = 0;   // 0: always ready, 1: random, 2: hold low
    logic       prev_busy = 1'b0;
    logic       armed = 1'b0;
    int         lat = 0;
    int         exp_lat = 0;
    logic       sel_seen = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: rotate right by (amt*cnt) mod 4, by plain arithmetic.
    function automatic logic [3:0] rot_ref(input logic [3:0] d, input int a, input int c);
        int k;
        int x;
        k = (a * c) % 4;
        x = int'({d, d});
        return 4'((x >> k) & 15);
    endfunction

    // Slow shifter: output only reflects new inputs once they have been
    // stable for S-1 cycles; before that the previous result persists.
    logic [5:0] sh_last = 6'd0;
    int         sh_age  = 0;
    always @(negedge clk) begin
        if ({sh_a, sh_s1, sh_s0} !== sh_last) begin
            sh_last = {sh_a, sh_s1, sh_s0};
            sh_age  = 0;
        end else if (sh_age < 100) begin
            sh_age++;
        end
        if (sh_age >= S - 1) begin
            sh_o = 4'(int'({sh_a, sh_a}) >> int'({sh_s1, sh_s0}));
        end
    end

    // Monitor: accept detection, latency, result ordering, select rules.
    always @(negedge clk) begin
        if (busy && !prev_busy) begin
            exp_q.push_back(rot_ref(pend_d, int'(pend_a), pend_c));
            exp_lat = (pend_c == 0) ? 0 : pend_c * S;
            lat     = 0;
            armed   = 1'b1;
        end else if (armed) begin
            lat++;
        end
        // Back in IDLE with nothing delivered: the command was discarded.
        if (!busy && !out_valid && exp_q.size() != 0) begin
            exp_q.delete();
            armed = 1'b0;
        end
        if (armed && out_valid) begin
            check("latency", lat, exp_lat);
            armed = 1'b0;
        end
        prev_busy = busy;

        case (rdy_mode)
            1:       out_ready = 1'($urandom_range(0, 1));
            2:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase

        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                check("out_data", int'(out_data), int'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end

        if (state_dbg == 2'd1 && (sh_q.size() == 0 || sh_a != sh_q[$])) begin
            sh_q.push_back(sh_a);
        end
        if (sh_s1 || sh_s0) sel_seen = 1'b1;
        if (state_dbg != 2'd1) check("idle_sel", int'({sh_s1, sh_s0}), 0);
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d, input logic [1:0] a, input int c);
        logic ok;
        ok       = 1'b0;
        pend_d   = d;
        pend_a   = a;
        pend_c   = c;
        in_data  = d;
        in_amt   = a;
        in_cnt   = CNT_W'(c);
        in_valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                step();
                break;
            end
            step();
        end
        in_valid = 1'b0;
        check("send_accepted", int'(ok), 1);
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && in_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("wait_idle", int'(ok), 1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_state"}, int'(state_dbg), 0);
        check({tag, "_in_ready"}, int'(in_ready), 1);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_sel"}, int'({sh_s1, sh_s0}), 0);
        check({tag, "_sh_a"}, int'(sh_a), 0);
        check({tag, "_out_data"}, int'(out_data), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic ok;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 4'd0;
        in_amt   = 2'd0;
        in_cnt   = '0;
        pend_d   = 4'd0;
        pend_a   = 2'd0;
        pend_c   = 0;
        repeat (3) step();
        check_reset_state("por");
        rst = 1'b0;
        step();

        // Reset in the middle of a 4-pass command; nothing may come out.
        send(4'b1010, 2'd1, 4);
        repeat (2) step();
        rst = 1'b1;
        step();
        check("mid_state", int'(state_dbg), 0);
        check("mid_in_ready", int'(in_ready), 1);
        check("mid_out_valid", int'(out_valid), 0);
        check("mid_sel", int'({sh_s1, sh_s0}), 0);
        rst = 1'b0;
        repeat (30) step();
        check("mid_no_result", int'(out_valid), 0);

        // Recovery: single pass, latency checked by the monitor.
        send(4'b1000, 2'd1, 1);
        wait_idle();

        // Multi-pass: shifter input walks through each intermediate word.
        sh_q.delete();
        send(4'b1000, 2'd1, 3);
        wait_idle();
        check("mp_steps", sh_q.size(), 3);
        if (sh_q.size() >= 3) begin
            check("mp_sh0", int'(sh_q[0]), 4'b1000);
            check("mp_sh1", int'(sh_q[1]), 4'b0100);
            check("mp_sh2", int'(sh_q[2]), 4'b0010);
        end

        // Identity paths.
        send(4'b0110, 2'd2, 2);
        wait_idle();
        sel_seen = 1'b0;
        send(4'b1101, 2'd3, 0);
        wait_idle();
        check("cnt0_sel_used", int'(sel_seen), 0);

        // Settle: an early capture would grab the stale shifter value.
        send(4'b0011, 2'd3, 1);
        wait_idle();

        // Back-pressure with a competing command held on the input.
        rdy_mode = 2;
        send(4'b0110, 2'd1, 2);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("bp_done_reached", int'(ok), 1);
        in_data  = 4'b1011;
        in_amt   = 2'd2;
        in_cnt   = CNT_W'(1);
        in_valid = 1'b1;
        repeat (10) begin
            step();
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
        end
        rdy_mode = 0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("bp_released", int'(ok), 1);
        check("bp_idle_in_ready", int'(in_ready), 1);
        send(4'b1011, 2'd2, 1);
        wait_idle();

        // Random back-to-back stream with random consumer stalls.
        rdy_mode = 1;
        for (int n = 0; n < 16; n++) begin
            send(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 int'($urandom_range(0, 2**CNT_W - 1)));
        end
        wait_idle();
        rdy_mode = 0;
        repeat (5) step();
        check("drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
